// File: rtl/value_display_seq_pkg.sv
// -----------------------------------------------------------------------------
// value_display_pkg
//   Shared definitions for the value-to-7-segment display engine:
//   - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - FSM state encoding
//   - bcd_digits(): number of BCD digits needed to hold 2^width-1
// -----------------------------------------------------------------------------
package value_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    // ceil(width * log10(2)) in integer arithmetic. width*log10(2) is never
    // an integer for width > 0, so this equals the digit count of 2^width-1.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/value_display_seq_if.sv
// -----------------------------------------------------------------------------
// value_display_seq_if
//   Request/result bundle between the operand logic (master) and the display
//   engine (slave).
//
//   Handshake: START is a request level sampled on every rising clock edge;
//   it is accepted only on an edge where the engine is idle (BUSY low, which
//   includes the DONE cycle). VALUE and MODE are captured on that same edge
//   and may change afterwards. START seen while BUSY is high is dropped, not
//   queued. DONE pulses for exactly one cycle after HEX has been updated.
//
//   Signals:
//     VALUE     master->slave  WIDTH     unsigned operand
//     MODE      master->slave  1         0 = hex, 1 = decimal
//     START     master->slave  1         conversion request
//     BUSY      slave->master  1         conversion in progress
//     DONE      slave->master  1         one-cycle completion pulse
//     HEX       slave->master  7*DIGITS  active-low segments, digit d at [7d+6:7d]
//     dbg_state slave->master  state_t   current FSM state, for observation
// -----------------------------------------------------------------------------
interface value_display_seq_if
    import value_display_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 8
);
    logic [WIDTH-1:0]    VALUE;
    logic                MODE;
    logic                START;
    logic                BUSY;
    logic                DONE;
    logic [7*DIGITS-1:0] HEX;
    state_t              dbg_state;

    modport master (
        output VALUE, MODE, START,
        input  BUSY, DONE, HEX, dbg_state
    );

    modport slave (
        input  VALUE, MODE, START,
        output BUSY, DONE, HEX, dbg_state
    );
endinterface

// File: rtl/value_display_seq_seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
//   Combinational hex nibble to active-low 7-segment pattern.
//   Ports:
//     nibble  in   4  value 0..F
//     seg     out  7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_encode
    import value_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/value_display_seq.sv
// -----------------------------------------------------------------------------
// value_display_seq
//   Sequential value-to-7-segment display engine. Latches VALUE/MODE on an
//   accepted START, converts to hex in one pass or to decimal by iterative
//   double-dabble (one bit per clock), then loads all HEX digits in a single
//   edge with optional leading-zero blanking and overflow dashes.
//
//   Parameters:
//     WIDTH     operand width (>= 4)
//     DIGITS    number of displays driven (1..8)
//     BLANK_LZ  1 = blank leading zeros in decimal mode (digit 0 always shown)
//   Ports:
//     CLOCK_50  in   sole clock, rising edge
//     RESET_N   in   asynchronous active-low reset
//     bus       value_display_seq_if.slave (VALUE, MODE, START, BUSY, DONE,
//               HEX, dbg_state)
// -----------------------------------------------------------------------------
module value_display_seq
    import value_display_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    value_display_seq_if.slave  bus
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH + 1);
    // Zero-extended views let the digit selection and the "anything above
    // the displayed digits" tests use one expression for every parameter set.
    localparam int VEXT_W     = WIDTH + 4 * DIGITS;
    localparam int BEXT_W     = 4 * (BCD_DIGITS + DIGITS);

    state_t              state_q;
    logic [WIDTH-1:0]    value_r;
    logic                mode_r;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [7*DIGITS-1:0] hex_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [VEXT_W-1:0]   value_ext;
    logic [BEXT_W-1:0]   bcd_ext;
    logic                hex_ovf;
    logic                dec_ovf;
    logic                overflow;
    logic [7*DIGITS-1:0] next_hex;

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign value_ext = VEXT_W'(value_r);
    assign bcd_ext   = BEXT_W'(bcd_q);
    assign hex_ovf   = ((value_ext >> (4 * DIGITS)) != '0);
    assign dec_ovf   = ((bcd_ext >> (4 * DIGITS)) != '0);
    assign overflow  = mode_r ? dec_ovf : hex_ovf;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [3:0] nib;
        logic [6:0] seg;
        logic       lz_blank;

        assign nib = mode_r ? bcd_ext[4*d +: 4] : value_ext[4*d +: 4];

        seg7_encode u_enc (
            .nibble (nib),
            .seg    (seg)
        );

        // Blank when this digit and every digit above it are zero.
        assign lz_blank = (d != 0) && (BLANK_LZ != 0) && mode_r &&
                          ((bcd_ext >> (4 * d)) == '0);

        assign next_hex[7*d +: 7] = overflow ? SEG_DASH  :
                                    lz_blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            value_r <= '0;
            mode_r  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        value_r <= bus.VALUE;
                        mode_r  <= bus.MODE;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= bus.MODE ? SHIFT : ENCODE;
                    end
                end
                SHIFT: begin
                    bcd_q   <= {bcd_adj[BCD_W-2:0], value_r[WIDTH-1]};
                    value_r <= {value_r[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_W'(1);
                    // Counter at 1 means this edge performs the last shift.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    hex_q   <= next_hex;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.HEX       = hex_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_value_display_seq.sv
// -----------------------------------------------------------------------------
// tb_value_display_seq
//   Two engines share clock and reset:
//     u_dut8: WIDTH=16, DIGITS=8, BLANK_LZ=1
//     u_dut4: WIDTH=16, DIGITS=4, BLANK_LZ=0 (decimal overflow, no blanking)
//   sel_r chooses which engine receives START and which one is observed.
// -----------------------------------------------------------------------------
module tb_value_display_seq;

    localparam logic [6:0] T0 = 7'b1000000;
    localparam logic [6:0] T1 = 7'b1111001;
    localparam logic [6:0] T2 = 7'b0100100;
    localparam logic [6:0] T3 = 7'b0110000;
    localparam logic [6:0] T4 = 7'b0011001;
    localparam logic [6:0] T5 = 7'b0010010;
    localparam logic [6:0] T7 = 7'b1111000;
    localparam logic [6:0] T9 = 7'b0010000;
    localparam logic [6:0] TF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic clk;
    logic rst_n;

    logic        sel_r;
    logic        start_r;
    logic [15:0] value_r;
    logic        mode_r;

    int checks;
    int errors;

    value_display_seq_if #(.WIDTH(16), .DIGITS(8)) b8 ();
    value_display_seq_if #(.WIDTH(16), .DIGITS(4)) b4 ();

    value_display_seq #(.WIDTH(16), .DIGITS(8), .BLANK_LZ(1)) u_dut8 (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (b8.slave)
    );

    value_display_seq #(.WIDTH(16), .DIGITS(4), .BLANK_LZ(0)) u_dut4 (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (b4.slave)
    );

    assign b8.VALUE = value_r;
    assign b8.MODE  = mode_r;
    assign b8.START = start_r & ~sel_r;
    assign b4.VALUE = value_r;
    assign b4.MODE  = mode_r;
    assign b4.START = start_r & sel_r;

    logic [55:0] cur_hex;
    logic        cur_busy;
    logic        cur_done;
    assign cur_hex  = sel_r ? {{4{BL}}, b4.HEX} : b8.HEX;
    assign cur_busy = sel_r ? b4.BUSY : b8.BUSY;
    assign cur_done = sel_r ? b4.DONE : b8.DONE;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference: what the displays should read for a given number, computed
    // with ordinary division/powers. Unused upper displays read blank.
    function automatic logic [55:0] model_hex(input int unsigned v, input bit dec,
                                              input int digits, input bit blz);
        logic [55:0] r;
        longint      lim;
        longint      p;
        int          nd;
        int unsigned t;
        r = {8{BL}};
        if (!dec) begin
            lim = longint'(1) << (4 * digits);
            for (int d = 0; d < digits; d++)
                r[7*d +: 7] = (longint'(v) >= lim) ? DS : seg_of(int'((v >> (4 * d)) & 15));
        end else begin
            lim = 1;
            for (int d = 0; d < digits; d++) lim = lim * 10;
            nd = 1;
            t = v;
            while (t >= 10) begin
                t = t / 10;
                nd++;
            end
            p = 1;
            for (int d = 0; d < digits; d++) begin
                if (longint'(v) >= lim)  r[7*d +: 7] = DS;
                else if (blz && d >= nd) r[7*d +: 7] = BL;
                else                     r[7*d +: 7] = seg_of(int'((longint'(v) / p) % 10));
                p = p * 10;
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Waits for DONE on the selected engine; HEX must hold its old value
    // until the update edge.
    task automatic wait_done(input int max, input logic [55:0] prev,
                             output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < max) begin
            @(posedge clk);
            #1;
            lat++;
            if (cur_done) got = 1'b1;
            else check("hex_hold", cur_hex, prev);
        end
        check("done_timeout", got, 1'b1);
    endtask

    task automatic run_conv(input string name, input bit sel, input logic [15:0] v,
                            input bit dec, input logic [55:0] exp_hex, input int exp_lat);
        logic [55:0] prev;
        int lat;
        bit got;
        @(negedge clk);
        sel_r   = sel;
        value_r = v;
        mode_r  = dec;
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        value_r = 16'($urandom_range(0, 65535));
        mode_r  = 1'($urandom_range(0, 1));
        check({name, "_busy_rise"}, cur_busy, 1'b1);
        prev = cur_hex;
        wait_done(40, prev, lat, got);
        if (got) begin
            check({name, "_latency"}, lat, exp_lat);
            check({name, "_hex"}, cur_hex, exp_hex);
            check({name, "_busy_fall"}, cur_busy, 1'b0);
        end
        @(posedge clk);
        #1;
        check({name, "_done_width"}, cur_done, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        bit          sel;
        logic [15:0] value;
        bit          dec;
        logic [55:0] exp_hex;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        bit got;
        int done_seen;
        logic [55:0] exp;
        logic [55:0] prev;

        checks  = 0;
        errors  = 0;
        sel_r   = 1'b0;
        start_r = 1'b0;
        value_r = '0;
        mode_r  = 1'b0;

        vecs[0] = '{"hex_00ff",   1'b0, 16'h00FF, 1'b0, {{6{T0}}, TF, TF},          1};
        vecs[1] = '{"dec_255",    1'b0, 16'd255,  1'b1, {{5{BL}}, T2, T5, T5},      17};
        vecs[2] = '{"dec_0",      1'b0, 16'd0,    1'b1, {{7{BL}}, T0},              17};
        vecs[3] = '{"hex_ffff",   1'b0, 16'hFFFF, 1'b0, {{4{T0}}, {4{TF}}},         1};
        vecs[4] = '{"ovf_65535",  1'b1, 16'd65535,1'b1, {{4{BL}}, {4{DS}}},         17};
        vecs[5] = '{"dec_9999",   1'b1, 16'd9999, 1'b1, {{4{BL}}, {4{T9}}},         17};
        vecs[6] = '{"dec4_1234",  1'b1, 16'd1234, 1'b1, {{4{BL}}, T1, T2, T3, T4},  17};
        vecs[7] = '{"dec4_7_nolz",1'b1, 16'd7,    1'b1, {{4{BL}}, T0, T0, T0, T7},  17};

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_hex8",  b8.HEX, {8{BL}});
        check("rst_hex4",  b4.HEX, {4{BL}});
        check("rst_busy8", b8.BUSY, 1'b0);
        check("rst_done8", b8.DONE, 1'b0);
        check("rst_busy4", b4.BUSY, 1'b0);
        check("rst_done4", b4.DONE, 1'b0);
        done_seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (b8.DONE || b4.DONE) done_seen++;
        end
        check("no_done_without_start", done_seen, 0);

        // ---- table ----
        for (int i = 0; i < 8; i++)
            run_conv(vecs[i].name, vecs[i].sel, vecs[i].value, vecs[i].dec,
                     vecs[i].exp_hex, vecs[i].exp_lat);

        // ---- START held during BUSY is ignored ----
        @(negedge clk);
        sel_r = 1'b0; value_r = 16'd1000; mode_r = 1'b1; start_r = 1'b1;
        @(posedge clk);
        #1;
        value_r = 16'd9;
        prev = cur_hex;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("held_start_busy", cur_busy, 1'b1);
        end
        start_r = 1'b0;
        wait_done(40, prev, lat, got);
        if (got) begin
            check("held_start_latency", lat + 8, 17);
            check("held_start_hex", cur_hex, {{4{BL}}, T1, T0, T0, T0});
        end
        @(posedge clk);
        #1;
        check("held_start_idle", cur_busy, 1'b0);

        // ---- START in the DONE cycle is accepted ----
        @(negedge clk);
        sel_r = 1'b0; value_r = 16'd42; mode_r = 1'b1; start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        prev = cur_hex;
        wait_done(40, prev, lat, got);
        check("b2b_first_hex", cur_hex, {{6{BL}}, T4, T2});
        value_r = 16'h0077; mode_r = 1'b0; start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        check("b2b_accept_busy", cur_busy, 1'b1);
        check("b2b_accept_done", cur_done, 1'b0);
        check("b2b_hold_old", cur_hex, {{6{BL}}, T4, T2});
        @(posedge clk);
        #1;
        check("b2b_second_done", cur_done, 1'b1);
        check("b2b_second_hex", cur_hex, {{6{T0}}, T7, T7});

        // ---- reset mid-conversion ----
        @(negedge clk);
        sel_r = 1'b0; value_r = 16'd5555; mode_r = 1'b1; start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_hex",  b8.HEX, {8{BL}});
        check("abort_busy", b8.BUSY, 1'b0);
        check("abort_done", b8.DONE, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (b8.DONE) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_conv("after_abort_1234", 1'b0, 16'd1234, 1'b1, {{4{BL}}, T1, T2, T3, T4}, 17);

        // ---- randomized against the reference model ----
        for (int i = 0; i < 40; i++) begin
            bit          s;
            bit          dm;
            logic [15:0] v;
            s  = 1'($urandom_range(0, 1));
            dm = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99))
                                             : 16'($urandom_range(0, 65535));
            exp = s ? model_hex(v, dm, 4, 1'b0) : model_hex(v, dm, 8, 1'b1);
            run_conv("rand", s, v, dm, exp, dm ? 17 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/value_display_seq.md
# value_display_seq

Sequential, parametrised value-to-7-segment display engine for the DE2 board.
- Latches a WIDTH-bit unsigned value on a START handshake.
- Converts it to hex (single pass) or decimal (iterative double-dabble, one bit per clock).
- Drives DIGITS active-low 7-segment displays with registered segment patterns, optional leading-zero blanking and overflow indication.
- Sits between switch/operand logic and the HEX outputs, and supersedes the purely combinational display path.

## Interface
- WIDTH, 16: width of VALUE in bits, ≥4.
- DIGITS, 8: number of 7-segment displays driven, 1–8.
- BLANK_LZ, 1: 1 blanks leading zeros in decimal mode; digit 0 is always shown.

Ports:
- CLOCK_50  in  1: sole clock, rising edge.
- RESET_N  in  1: reset, asynchronous, active-low.
- VALUE  in  WIDTH: unsigned value, sampled only on an accepted START.
- MODE  in  1: 0 = hex, 1 = decimal; sampled with VALUE.
- START  in  1: conversion request; accepted only in IDLE.
- BUSY  out  1: high while a conversion is in progress.
- DONE  out  1: one-cycle pulse, high on the cycle after HEX is updated.
- HEX  out  7*DIGITS: display d occupies HEX[7d+6:7d]; bit order {g,f,e,d,c,b,a}; active-low.

## Operation
- States are IDLE, SHIFT and ENCODE.
- IDLE:
  - When START=1, latch VALUE and MODE, clear the BCD register and load the bit counter with WIDTH.
  - Go to SHIFT if MODE=1, otherwise to ENCODE.
  - When START=0, hold all outputs.
- SHIFT performs one double-dabble iteration per clock:
  - Add 3 to each BCD digit that is ≥5.
  - Shift {bcd, value} left by 1 and decrement the counter.
  - When the counter reaches 1 at the clock edge, go to ENCODE.
- ENCODE:
  - Load every HEX digit in one edge.
  - Assert DONE for the next cycle.
  - Return to IDLE.
- Hex encoding:
  - Digit d shows nibble d of VALUE; nibbles beyond WIDTH read as 0.
  - If WIDTH > 4*DIGITS and any bit above 4*DIGITS-1 is set, every digit shows a dash.
- Decimal encoding:
  - The BCD register holds BCD_DIGITS digits, enough for 2^WIDTH−1.
  - If any BCD digit at index ≥ DIGITS is nonzero, every digit shows a dash (overflow).
  - With BLANK_LZ=1, digits above the most significant nonzero digit are blank; digit 0 always shows.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Dash = 0111111, blank = 1111111.
- START while BUSY=1 is ignored; it is not queued.
- START in the DONE cycle is accepted, because the state is then IDLE.
- Asserting RESET_N low at any time, including mid-conversion:
  - Aborts the conversion and returns to IDLE.
  - Forces every HEX digit to blank, and BUSY and DONE to 0.
  - DONE is never issued for the aborted request.

## Timing
- START accepted at edge k:
  - BUSY is high from edge k.
  - Hex mode: HEX is updated at edge k+1. Decimal mode: HEX is updated at edge k+WIDTH+1.
  - BUSY falls and DONE rises at that same update edge.
  - DONE falls one edge later.
- Decimal latency = WIDTH+1 clocks; hex latency = 1 clock.
- HEX changes only at the ENCODE edge, so there are no intermediate patterns. Between conversions HEX holds its last value.
- VALUE and MODE may change freely after the accept edge.

## Structure
- The package value_display_pkg holds:
  - The segment constants (SEG_0..SEG_F, SEG_DASH, SEG_BLANK).
  - The state enum (IDLE, SHIFT, ENCODE).
  - The function bcd_digits(WIDTH) = ceil(WIDTH*log10(2)).
- The sub-module seg7_encode is combinational: 4-bit nibble in, 7-bit active-low segments out. It is instantiated once per display digit.
- The top module contains the FSM, the bit counter, the double-dabble datapath, the overflow/blanking logic and the HEX registers.

## Test plan
- Reset: hold RESET_N=0, then release → HEX all 1111111, BUSY=0, DONE=0; no DONE without START.
- Hex mode, VALUE=16'h00FF, MODE=0 → one clock later HEX1=HEX0=0001110 and HEX7..HEX2=1000000; DONE pulse one cycle wide.
- Decimal mode, VALUE=255, MODE=1, BLANK_LZ=1:
  - DONE follows the accept edge by 17 edges.
  - HEX2=0100100, HEX1=HEX0=0010010, HEX7..HEX3 blank.
  - VALUE=0 gives HEX0=1000000 with the rest blank.
- Overflow, DIGITS=4, decimal 65535 → all four digits 0111111. Decimal 9999 → 0010000 on all four digits.
- Handshake:
  - START held high during BUSY is ignored.
  - START in the DONE cycle begins a new conversion, and its result replaces the old one at the expected edge.
- Reset mid-operation: RESET_N low at SHIFT cycle 5 → immediate blank and IDLE. A following START of 1234 decimal yields HEX3..HEX0 = 1,2,3,4 codes.
